// File: rtl/prog_ctrl_pkg.sv
// rtl/prog_ctrl_pkg.sv - shared states and constants for the program-run sequencer
`timescale 1ns/1ps
package prog_ctrl_pkg;

  // Sequencer states, in session order
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_RD    = 3'd4,
    ST_WT    = 3'd5,
    ST_OUT   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Opcode field [31:26] of the processor's halt instruction
  localparam logic [5:0] HLT_OPCODE = 6'h3F;

  // RUN budget in clk1 cycles before the session is declared timed out
  localparam int DEFAULT_MAX_CYCLES = 1000;

endpackage

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - saturating RUN cycle counter with budget compare
`timescale 1ns/1ps
module run_watchdog
  import prog_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_inc;

  // Next count: clear wins, otherwise a saturating increment while enabled
  always_comb begin
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_inc;
    end
  end

  // Counter register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expire on the enabled cycle whose increment reaches the budget, so the
  // count reads exactly MAX_CYCLES once the run has been stopped
  assign expire = enable && !clear && (32'(count_inc) == 32'(MAX_CYCLES));
  assign count  = count_q;

endmodule

// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - host sequencer: load program, clear and run the core, dump a result window
`timescale 1ns/1ps
module prog_run_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              mem_own,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_clear,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;
  logic              cpu_run_q, cpu_run_d;
  logic              cpu_clear_q, cpu_clear_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic              start_ok;
  logic              halt_seen;
  logic              load_hs;
  logic              out_hs;
  logic              wd_enable;
  logic              wd_expire;
  logic [CNT_W-1:0]  wd_count;

  // Stream handshakes; abort blocks a load beat so nothing is half-written
  assign load_hs   = (state_q == ST_LOAD) && s_valid && !abort;
  assign out_hs    = (state_q == ST_OUT) && m_valid_q && m_ready;
  assign wd_enable = (state_q == ST_RUN) && !abort;

  run_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_watchdog (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .clear  (start_ok),
    .enable (wd_enable),
    .count  (wd_count),
    .expire (wd_expire)
  );

  // Next-state, dump pointer bookkeeping and registered-output targets
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    timeout_d = timeout_q;
    start_ok  = 1'b0;
    halt_seen = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            start_ok  = 1'b1;
            ptr_d     = dump_base;
            rem_d     = dump_len;
            timeout_d = 1'b0;
            state_d   = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_hs && s_last) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          // A zero count marks the first RUN cycle, where HALTED may still be stale
          halt_seen = cpu_halted && (wd_count != '0);
          if (halt_seen) begin
            state_d = (rem_q == '0) ? ST_DONE : ST_RD;
          end else if (wd_expire) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
        ST_RD: begin
          state_d = ST_WT;
        end
        ST_WT: begin
          m_data_d = mem_rdata;
          m_last_d = (rem_q == ADDR_W'(1));
          state_d  = ST_OUT;
        end
        ST_OUT: begin
          if (out_hs) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            rem_d   = rem_q - ADDR_W'(1);
            state_d = (rem_q == ADDR_W'(1)) ? ST_DONE : ST_RD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    cpu_run_d   = (state_d == ST_RUN);
    cpu_clear_d = (state_d == ST_CLEAR);
    m_valid_d   = (state_d == ST_OUT);
    done_d      = (state_d == ST_DONE);
  end

  // State and registered outputs; reset leaves memory untouched
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      cpu_run_q   <= 1'b0;
      cpu_clear_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      cpu_run_q   <= cpu_run_d;
      cpu_clear_q <= cpu_clear_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Memory port: stream beats write straight through; RD reads at the dump pointer
  assign mem_own   = (state_q != ST_RUN);
  assign mem_we    = load_hs;
  assign mem_re    = (state_q == ST_RD) && !abort;
  assign mem_addr  = (state_q == ST_LOAD) ? s_addr : ptr_q;
  assign mem_wdata = s_data;

  // Abort drops run and dump valid in the same cycle it is seen
  assign s_ready     = (state_q == ST_LOAD) && !abort;
  assign cpu_run     = cpu_run_q && !abort;
  assign cpu_clear   = cpu_clear_q;
  assign m_valid     = m_valid_q && !abort;
  assign m_addr      = ptr_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = wd_count;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb/tb_prog_run_ctrl.sv - randomized session bench for prog_run_ctrl with behavioural memory and core stand-in
`timescale 1ns/1ps
module tb_prog_run_ctrl;
  import prog_ctrl_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int MAX_CYC = 100;
  localparam int MEM_N   = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] dump_base = '0;
  logic [ADDR_W-1:0] dump_len = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              mem_own, mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              cpu_clear, cpu_run;
  logic              cpu_halted = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  cycle_count;

  prog_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYC)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .dump_base(dump_base), .dump_len(dump_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .mem_own(mem_own), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_clear(cpu_clear), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] fact_f(input logic [31:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h08;
    return w;
  endfunction

  // Memory and core stand-in: the core's clear settles one cycle after
  // cpu_clear, so HALTED from the previous session is visible on RUN cycle 1
  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  int   core_halt_at = 0;
  logic core_fact = 1'b0;
  int   core_cnt = 0;
  logic clr_dly = 1'b0;
  always @(posedge clk1) begin
    if (mem_own && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_own && mem_re) mem_rdata <= mem[mem_addr];
    clr_dly <= cpu_clear;
    if (clr_dly) begin
      core_cnt   <= 0;
      cpu_halted <= 1'b0;
    end else if (cpu_run && !cpu_halted) begin
      core_cnt <= core_cnt + 1;
      if (core_halt_at != 0 && core_cnt + 1 == core_halt_at) begin
        cpu_halted <= 1'b1;
        if (core_fact) mem[198] <= fact_f(mem[200]);
      end
    end
  end

  // Monitor: monotonic event counters and logs, sampled mid-cycle
  int clr_pulses = 0, run_cycles = 0, we_bad = 0, stall_bad = 0, re_bad = 0;
  logic [ADDR_W-1:0] wr_a[$];
  logic [DATA_W-1:0] wr_d[$];
  logic [ADDR_W-1:0] bt_a[$];
  logic [DATA_W-1:0] bt_d[$];
  logic              bt_l[$];
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [ADDR_W-1:0] pa = '0;
  logic [DATA_W-1:0] pd = '0;
  always @(negedge clk1) begin
    if (rst_n) begin
      if (cpu_clear) clr_pulses <= clr_pulses + 1;
      if (cpu_run) run_cycles <= run_cycles + 1;
      if (mem_we) begin
        if (!(s_valid && s_ready && mem_own)) we_bad <= we_bad + 1;
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_wdata);
      end
      if (mem_re && !mem_own) re_bad <= re_bad + 1;
      if (pv && !pr && m_valid && (m_addr !== pa || m_data !== pd || m_last !== pl))
        stall_bad <= stall_bad + 1;
      if (m_valid && m_ready) begin
        bt_a.push_back(m_addr);
        bt_d.push_back(m_data);
        bt_l.push_back(m_last);
      end
      pv <= m_valid; pr <= m_ready; pa <= m_addr; pd <= m_data; pl <= m_last;
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  logic [ADDR_W-1:0] ld_a[$];
  logic [DATA_W-1:0] ld_d[$];

  task automatic load_only(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                           input bit gaps);
    dump_base = base; dump_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    dump_base = ADDR_W'($urandom); dump_len = ADDR_W'($urandom);
    check("load_entered", s_ready, 1);
    for (int i = 0; i < ld_a.size(); i++) begin
      if (gaps) begin
        s_valid = 1'b0; s_addr = ADDR_W'($urandom); s_data = $urandom;
        repeat ($urandom_range(0, 2)) tick();
      end
      s_valid = 1'b1; s_addr = ld_a[i]; s_data = ld_d[i]; s_last = (i == ld_a.size() - 1);
      begin
        int b = 0;
        while (!s_ready && b < 20) begin tick(); b++; end
      end
      tick();
      ref_mem[ld_a[i]] = ld_d[i];
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic set_core(input int halt_at, input bit do_fact);
    bit halts = 1'b0;
    foreach (ld_d[i]) if (ld_d[i][31:26] == HLT_OPCODE) halts = 1'b1;
    core_halt_at = halts ? halt_at : 0;
    core_fact = do_fact;
  endtask

  task automatic session(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                         input int halt_at, input bit gaps, input bit stall, input bit do_fact);
    int c0, r0, w0, b0, budget, scnt, exp_cc, exp_beats;
    bit exp_to;
    c0 = clr_pulses; r0 = run_cycles; w0 = wr_a.size(); b0 = bt_a.size();
    set_core(halt_at, do_fact);
    load_only(base, len, gaps);
    // Core halts after halt_at counted cycles, counting starts on RUN cycle 2
    if (core_halt_at != 0 && halt_at + 2 <= MAX_CYC) begin
      exp_cc = halt_at + 2; exp_to = 1'b0;
    end else begin
      exp_cc = MAX_CYC; exp_to = 1'b1;
    end
    if (do_fact && !exp_to) ref_mem[198] = fact_f(ref_mem[200]);
    exp_beats = exp_to ? 0 : int'(len);
    budget = 0; scnt = 0; m_ready = !stall;
    while (!done && budget < 3000) begin
      if (stall) begin
        if (m_valid && scnt < 5) begin m_ready = 1'b0; scnt++; end
        else if (m_valid) begin m_ready = 1'b1; scnt = 0; end
        else m_ready = 1'b0;
      end
      tick();
      budget++;
    end
    m_ready = 1'b0;
    check("done", done, 1);
    check("timeout", timeout, exp_to);
    check("cycle_count", cycle_count, exp_cc);
    check("run_cycles", run_cycles - r0, exp_cc);
    check("clear_pulses", clr_pulses - c0, 1);
    check("busy_done", busy, 0);
    check("write_count", wr_a.size() - w0, ld_a.size());
    for (int i = 0; i < ld_a.size() && w0 + i < wr_a.size(); i++) begin
      check("wr_addr", wr_a[w0 + i], ld_a[i]);
      check("wr_data", wr_d[w0 + i], ld_d[i]);
    end
    check("beat_count", bt_a.size() - b0, exp_beats);
    for (int i = 0; i < exp_beats; i++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(i);
      if (b0 + i < bt_a.size()) begin
        check("beat_addr", bt_a[b0 + i], a);
        check("beat_data", bt_d[b0 + i], ref_mem[a]);
        check("beat_last", bt_l[b0 + i], (i == exp_beats - 1));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $fatal(1, "FAIL global_time_limit: simulation did not finish");
  end

  initial begin
    int b0f, w0, b;
    logic [ADDR_W-1:0] rb;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst_cpu_run", cpu_run, 0);
    check("rst_cpu_clear", cpu_clear, 0);
    check("rst_mem_own", mem_own, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    tick();

    // Factorial session
    ld_a = {}; ld_d = {};
    ld_a.push_back(0); ld_d.push_back(32'h200A00C8);
    for (int i = 1; i <= 9; i++) begin ld_a.push_back(ADDR_W'(i)); ld_d.push_back(rand_word()); end
    ld_a.push_back(10);  ld_d.push_back(32'hFC000000);
    ld_a.push_back(200); ld_d.push_back(32'd7);
    b0f = bt_d.size();
    session(198, 1, 40, 1'b0, 1'b0, 1'b1);
    if (bt_d.size() > b0f) check("fact_5040", bt_d[b0f], 5040);

    // Timeout: branch-to-self never halts
    ld_a = {}; ld_d = {};
    ld_a.push_back(20); ld_d.push_back(32'h1000FFFF);
    session(20, 2, 5, 1'b0, 1'b0, 1'b0);

    // Abort in DONE keeps timeout, drops done
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_done", done, 0);
    check("abort_done_timeout", timeout, 1);
    check("abort_done_busy", busy, 0);

    // Abort during LOAD after four beats
    ld_a = {}; ld_d = {};
    core_halt_at = 0;
    dump_base = 300; dump_len = 2; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_timeout", timeout, 0);
    w0 = wr_a.size();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_addr = ADDR_W'(300 + i); s_data = rand_word(); s_last = 1'b0;
      ref_mem[s_addr] = s_data;
      tick();
    end
    s_addr = ADDR_W'(310); s_data = rand_word(); abort = 1'b1;
    #1;
    check("abort_s_ready", s_ready, 0);
    check("abort_mem_we", mem_we, 0);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    check("abort_load_busy", busy, 0);
    check("abort_load_run", cpu_run, 0);
    check("abort_load_done", done, 0);
    check("abort_load_writes", wr_a.size() - w0, 4);

    // Coincident halt and budget: halt wins
    ld_a = {}; ld_d = {};
    ld_a.push_back(710); ld_d.push_back(32'hFC000000);
    session(710, 1, 98, 1'b0, 1'b0, 1'b0);

    // Dump backpressure with address wrap
    ld_a = {}; ld_d = {};
    ld_a.push_back(1022); ld_d.push_back(rand_word());
    ld_a.push_back(1023); ld_d.push_back(rand_word());
    ld_a.push_back(0);    ld_d.push_back(rand_word());
    ld_a.push_back(1);    ld_d.push_back(32'hFC000000);
    session(1022, 3, 20, 1'b1, 1'b1, 1'b0);

    // Zero-length dump
    ld_a = {}; ld_d = {};
    for (int i = 0; i < 2; i++) begin ld_a.push_back(ADDR_W'(700 + i)); ld_d.push_back(rand_word()); end
    ld_a.push_back(702); ld_d.push_back(32'hFC000000);
    session(700, 0, 5, 1'b1, 1'b0, 1'b0);

    // Abort mid-RUN drops cpu_run in the same cycle
    ld_a = {}; ld_d = {};
    ld_a.push_back(400); ld_d.push_back(32'h1000FFFF);
    set_core(0, 1'b0);
    load_only(400, 1, 1'b0);
    b = 0;
    while (!cpu_run && b < 20) begin tick(); b++; end
    check("run_started_a", cpu_run, 1);
    abort = 1'b1;
    #1;
    check("abort_run_cpu_run", cpu_run, 0);
    tick();
    abort = 1'b0;
    check("abort_run_busy", busy, 0);
    check("abort_run_mem_own", mem_own, 1);

    // Asynchronous reset mid-RUN
    load_only(400, 1, 1'b0);
    b = 0;
    while (!cpu_run && b < 20) begin tick(); b++; end
    check("run_started_r", cpu_run, 1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_cpu_run", cpu_run, 0);
    check("arst_mem_own", mem_own, 1);
    check("arst_busy", busy, 0);
    check("arst_cycle_count", cycle_count, 0);
    @(posedge clk1);
    #1 rst_n = 1'b1;
    tick();

    // Clean session after reset; dumps words loaded before the reset
    ld_a = {}; ld_d = {};
    for (int i = 0; i < 3; i++) begin ld_a.push_back(ADDR_W'(500 + i)); ld_d.push_back(rand_word()); end
    ld_a.push_back(503); ld_d.push_back(32'hFC000000);
    session(300, 4, 10, 1'b1, 1'b0, 1'b0);

    // Randomized sessions
    for (int r = 0; r < 4; r++) begin
      ld_a = {}; ld_d = {};
      n = $urandom_range(2, 6);
      rb = ADDR_W'($urandom_range(600, 900));
      for (int k = 0; k < n; k++) begin
        ld_a.push_back(rb + ADDR_W'(k));
        ld_d.push_back((k == n - 1) ? 32'hFC000000 : rand_word());
      end
      session(rb, ADDR_W'($urandom_range(1, n)), $urandom_range(1, 60), 1'b1,
              1'($urandom_range(0, 1)), 1'b0);
    end

    check("mem_we_only_on_handshake", we_bad, 0);
    check("dump_stable_while_stalled", stall_bad, 0);
    check("no_read_while_core_owns", re_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Host-side sequencer for the pipelined processor and its unified instruction/data memory.
- Over a valid/ready stream it writes a program and its operands into memory, then pulses the processor's architectural clear (PC, HALTED, TAKEN_BRANCH).
- It releases the core to run, watches for halt or a cycle-budget timeout, then streams a result window of memory back out.
- It owns the memory port in every state except RUN.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, memory/instruction word width.
- CNT_W, 16, cycle-counter width.
- MAX_CYCLES, 1000, RUN budget in clk1 cycles before timeout.

Ports:
- clk1  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a session; sampled only in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- dump_base  in  ADDR_W  first address to read back; latched on start.
- dump_len  in  ADDR_W  number of words to read back; latched on start.
- s_valid  in  1  load beat valid.
- s_ready  out  1  controller accepts a load beat.
- s_addr  in  ADDR_W  load word address.
- s_data  in  DATA_W  load word.
- s_last  in  1  final load beat.
- mem_own  out  1  1 = controller drives memory, 0 = processor drives it.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe; data returns 1 cycle later.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- cpu_clear  out  1  one-cycle pulse: PC=0, HALTED=0, TAKEN_BRANCH=0.
- cpu_run  out  1  processor enabled.
- cpu_halted  in  1  processor HALTED flag.
- m_valid  out  1  dump beat valid.
- m_ready  in  1  dump sink ready.
- m_addr  out  ADDR_W  address of the dumped word.
- m_data  out  DATA_W  dumped word.
- m_last  out  1  final dump beat.
- busy  out  1  state is neither IDLE nor DONE.
- done  out  1  level, high in DONE.
- timeout  out  1  sticky; cleared on start.
- cycle_count  out  CNT_W  cycles spent in the last or current RUN.

Behaviour:
- Reset values:
  - Registered outputs are 0: cpu_run, cpu_clear, m_valid, done, timeout, cycle_count.
  - mem_own=1; state=IDLE.
  - Reset mid-session aborts immediately; memory contents are not touched.
- States: IDLE, LOAD, CLEAR, RUN, RD, WT, OUT, DONE.
- IDLE/DONE:
  - start -> LOAD.
  - Latch dump_base/dump_len; clear timeout and cycle_count.
- LOAD:
  - s_ready=1.
  - Each s_valid&s_ready beat drives mem_we=1, mem_addr=s_addr, mem_wdata=s_data in the same cycle (combinational from the stream).
  - The beat with s_last -> CLEAR. No beat is dropped.
- CLEAR: cpu_clear=1 for exactly one cycle -> RUN.
- RUN:
  - mem_own=0, cpu_run=1.
  - cycle_count increments each cycle and saturates at all-ones.
  - cpu_halted is ignored on the first RUN cycle, while the clear settles.
  - From the second RUN cycle, cpu_halted=1 -> cpu_run=0 next cycle, then to RD, or to DONE if dump_len=0.
  - cycle_count==MAX_CYCLES with no halt -> timeout=1, cpu_run=0, DONE with no dump.
  - If halt and budget coincide on the same cycle, halt wins and timeout stays 0.
- RD: mem_re=1, mem_addr=ptr -> WT.
- WT:
  - Capture mem_rdata into m_data; m_addr=ptr.
  - m_last = (remaining==1) -> OUT.
- OUT:
  - m_valid held with stable m_data, m_addr and m_last until m_ready.
  - On handshake: ptr+1 and remaining-1.
  - If remaining hits 0 -> DONE, else RD.
  - Per-word throughput is 3 cycles minimum.
- ptr wraps modulo 2^ADDR_W.
- abort:
  - Highest priority except reset; next state IDLE.
  - cpu_run=0, m_valid=0, mem_we=0 that cycle.
  - done=0; timeout keeps its value.
- Outside LOAD, s_ready=0. Outside RD, mem_re=0.

Decomposition:
- Shared package prog_ctrl_pkg holds:
  - the state enum;
  - the HLT opcode constant (6'h3F);
  - default MAX_CYCLES.
- One sub-module, run_watchdog: the saturating cycle counter plus budget compare. Inputs are clear/enable; outputs are count and expire.

Test Plan:
- Factorial session:
  - Stimulus: load 11 words at addresses 0-10 (ADDI R10,R0,200 ... HLT=32'hfc000000) and mem[200]=7 with s_last; dump_base=198, dump_len=1.
  - Response: one cpu_clear pulse; one beat m_addr=198, m_data=5040, m_last=1; done=1, timeout=0.
- Timeout:
  - Stimulus: MAX_CYCLES=100; program is a branch-to-self with no HLT.
  - Response: cpu_run falls after 100 RUN cycles; timeout=1, cycle_count=100, no m_valid.
- Dump backpressure:
  - Stimulus: dump_len=3; m_ready low for 5 cycles on each beat.
  - Response: m_data/m_addr stable while stalled; addresses base, base+1, base+2; m_last only on the third beat.
- Zero-length dump: dump_len=0 with a halting program -> DONE straight from RUN, m_valid never asserted.
- Abort and async reset:
  - Stimulus: abort during LOAD after 4 beats; then rst_n low mid-RUN.
  - Response: both return to IDLE with cpu_run=0 within one cycle (reset asynchronously); a following start runs cleanly.
- Load stall: s_valid gaps during LOAD -> mem_we asserted only on handshake cycles; written addresses match s_addr exactly.
